axi_write_arbiter: RTL and testbench
====================================

AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

Interface
REQ-001 The block SHALL take clk, the rising-edge clock for all state.
REQ-002 The block SHALL take reset, synchronous, active-high; clock clk.
REQ-003 The block SHALL have ports req0_we, req1_we: input, 1 bit each; write request from requester 0 (data-side store) and requester 1 (write buffer drain).
REQ-004 The block SHALL have ports req0_address, req1_address, req0_data, req1_data: input, 32 bits each; write address and write data per requester.
REQ-005 The block SHALL have ports req0_select, req1_select: input, 4 bits each; byte strobes per requester.
REQ-006 The block SHALL have ports req0_done, req1_done: output, 1 bit each; write-complete pulse per requester.
REQ-007 The block SHALL have ports we_o (output, 1), address_o (output, 32), data_o (output, 32), select_o (output, 4); these drive the downstream AXI write adapter.
REQ-008 The block SHALL have port mem_write_done: input, 1 bit; downstream write response (bvalid).
REQ-009 The block SHALL have port busy: output, 1 bit; high when the state is not IDLE.

Function
REQ-010 The block SHALL have the states IDLE, GRANT0, GRANT1 and RELEASE.
REQ-011 The block SHALL keep a 1-bit round-robin pointer rr; rr=0 means requester 0 is preferred.
REQ-012 In IDLE, sampled at a clock edge, the block SHALL arbitrate as follows.
- Only req0_we high: next state GRANT0.
- Only req1_we high: next state GRANT1.
- Both high: grant the requester indexed by rr.
- Neither high: stay in IDLE.
REQ-013 On entry to GRANTx, the block SHALL latch reqx_address, reqx_data and reqx_select into address_o, data_o and select_o, and set we_o=1, all in the same edge; outputs are registered.
REQ-014 The latency from reqx_we high in IDLE at edge t to we_o=1 SHALL be one cycle (visible after edge t).
REQ-015 In GRANTx, address_o, data_o, select_o and we_o SHALL hold stable, ignoring all requester inputs, until mem_write_done=1.
REQ-016 reqx_done SHALL equal mem_write_done AND (state==GRANTx) combinationally; the other done output SHALL stay 0.
REQ-017 On the edge where mem_write_done=1 in GRANTx, the block SHALL do all of the following.
- Next state RELEASE.
- we_o <= 0.
- rr <= ~x, so the other requester is preferred next.
REQ-018 RELEASE SHALL last exactly one cycle with we_o=0, so the adapter clears its address/data handshake-done flags; next state IDLE.
REQ-019 A new grant SHALL be possible no earlier than two edges after the done edge; the requester SHALL deassert reqx_we on the edge after its done pulse.
REQ-020 If reqx_we drops during GRANTx, the latched transaction SHALL still complete and reqx_done SHALL still pulse.
REQ-021 mem_write_done in IDLE or RELEASE SHALL be ignored: no done pulse, no state change.
REQ-022 In IDLE and RELEASE, address_o, data_o and select_o SHALL hold their last latched values.
REQ-023 busy SHALL be 1 in GRANT0, GRANT1 and RELEASE, and 0 in IDLE.

Reset
REQ-024 When reset=1 at an edge, the block SHALL set the following, overriding any in-flight grant.
- State IDLE.
- we_o=0, address_o=0, data_o=0, select_o=0.
- rr=0.
REQ-025 While reset=1, req0_done, req1_done and busy SHALL be 0.
REQ-026 After reset deasserts, the first arbitration SHALL occur at the first edge with reset=0.

Verification
REQ-027 Single request: req0_we=1, address 0x1FC00010, data 0xDEADBEEF, select 0xF; mem_write_done pulsed 3 cycles after we_o rises.
- Response: we_o=1 one cycle after the request, outputs equal the latched values, req0_done pulses in the same cycle as mem_write_done, we_o=0 for one RELEASE cycle.
REQ-028 Simultaneous requests after reset (both reqx_we=1, rr=0).
- Response: GRANT0 first; then RELEASE, IDLE, GRANT1.
- If both requesters re-request continuously, grants strictly alternate 0,1,0,1.
REQ-029 Input change mid-grant: during GRANT1, change req1_data from 0x11111111 to 0x22222222.
- Response: data_o stays 0x11111111 until the done edge.
REQ-030 Spurious response: mem_write_done=1 while in IDLE.
- Response: no done pulse; state remains IDLE.
REQ-031 Reset mid-operation: assert reset in GRANT0 before mem_write_done arrives.
- Response: next cycle we_o=0, busy=0, rr=0, address_o=0.
- A subsequent req1 is granted normally.

Source files
------------

// File: rtl/axi_write_arbiter.sv
// Two-requester write arbiter in front of the AXI write adapter.
// Round-robin on conflict; the granted request is latched and held until the write response.
module axi_write_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_we,
    input  logic        req1_we,
    input  logic [31:0] req0_address,
    input  logic [31:0] req1_address,
    input  logic [31:0] req0_data,
    input  logic [31:0] req1_data,
    input  logic [3:0]  req0_select,
    input  logic [3:0]  req1_select,
    output logic        req0_done,
    output logic        req1_done,
    output logic        we_o,
    output logic [31:0] address_o,
    output logic [31:0] data_o,
    output logic [3:0]  select_o,
    input  logic        mem_write_done,
    output logic        busy
);

    // state   | meaning
    // IDLE    | no grant, arbitrating each edge
    // GRANT0  | requester 0 transaction on the bus, waiting for response
    // GRANT1  | requester 1 transaction on the bus, waiting for response
    // RELEASE | one cycle with we_o low so the adapter clears its handshake flags
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT0  = 2'd1;
    localparam logic [1:0] GRANT1  = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       rr;
    logic       grant0;
    logic       grant1;
    logic       done_edge;

    // rr only matters when both requesters collide
    assign grant0    = (state == IDLE) && req0_we && (!req1_we || !rr);
    assign grant1    = (state == IDLE) && req1_we && (!req0_we ||  rr);
    assign done_edge = mem_write_done && ((state == GRANT0) || (state == GRANT1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant0)
                    state_next = GRANT0;
                else if (grant1)
                    state_next = GRANT1;
            end
            GRANT0:  if (mem_write_done) state_next = RELEASE;
            GRANT1:  if (mem_write_done) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr        <= 1'b0;
            we_o      <= 1'b0;
            address_o <= 32'd0;
            data_o    <= 32'd0;
            select_o  <= 4'd0;
        end else begin
            state <= state_next;
            if (grant0) begin
                we_o      <= 1'b1;
                address_o <= req0_address;
                data_o    <= req0_data;
                select_o  <= req0_select;
            end else if (grant1) begin
                we_o      <= 1'b1;
                address_o <= req1_address;
                data_o    <= req1_data;
                select_o  <= req1_select;
            end
            if (done_edge) begin
                we_o <= 1'b0;
                rr   <= (state == GRANT0);
            end
        end
    end

    // Reset is synchronous, so gate the combinational outputs while it is held.
    assign req0_done = !reset && mem_write_done && (state == GRANT0);
    assign req1_done = !reset && mem_write_done && (state == GRANT1);
    assign busy      = !reset && (state != IDLE);

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Cycle-by-cycle vector table for the write arbiter plus a hand-written latency/release sequence.
module tb_axi_write_arbiter;

    localparam logic [31:0] A0 = 32'h1FC0_0010;
    localparam logic [31:0] D0 = 32'hDEAD_BEEF;
    localparam logic [3:0]  S0 = 4'hF;
    localparam logic [31:0] A1 = 32'h0000_2000;
    localparam logic [31:0] DA = 32'h1111_1111;
    localparam logic [31:0] DB = 32'h2222_2222;
    localparam logic [3:0]  S1 = 4'h3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_we, req1_we;
    logic [31:0] req0_address, req1_address, req0_data, req1_data;
    logic [3:0]  req0_select, req1_select;
    logic        req0_done, req1_done;
    logic        we_o;
    logic [31:0] address_o, data_o;
    logic [3:0]  select_o;
    logic        mem_write_done;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_write_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_we(req0_we), .req1_we(req1_we),
        .req0_address(req0_address), .req1_address(req1_address),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_select(req0_select), .req1_select(req1_select),
        .req0_done(req0_done), .req1_done(req1_done),
        .we_o(we_o), .address_o(address_o), .data_o(data_o), .select_o(select_o),
        .mem_write_done(mem_write_done), .busy(busy)
    );

    typedef struct {
        logic        rst, w0, w1, mwd;
        logic [31:0] r1d;
        logic        we;
        logic [31:0] addr, data;
        logic [3:0]  sel;
        logic        dn0, dn1, bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic w0, logic w1, logic mwd, logic [31:0] r1d,
                                logic we, logic [31:0] addr, logic [31:0] data, logic [3:0] sel,
                                logic dn0, logic dn1, logic bsy);
        vec_t v;
        v.rst = rst; v.w0 = w0; v.w1 = w1; v.mwd = mwd; v.r1d = r1d;
        v.we = we; v.addr = addr; v.data = data; v.sel = sel;
        v.dn0 = dn0; v.dn1 = dn1; v.bsy = bsy;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //                rst w0 w1 mwd r1d   we addr data sel dn0 dn1 busy
        vecs.push_back(mk(1, 0, 0, 0, DA,   0, 0,  0,  0,  0, 0, 0)); // 0 reset held
        vecs.push_back(mk(0, 1, 0, 0, DA,   0, 0,  0,  0,  0, 0, 0)); // 1 req0 in IDLE
        vecs.push_back(mk(0, 1, 0, 0, DA,   1, A0, D0, S0, 0, 0, 1)); // 2 GRANT0
        vecs.push_back(mk(0, 1, 0, 0, DA,   1, A0, D0, S0, 0, 0, 1)); // 3
        vecs.push_back(mk(0, 1, 0, 0, DA,   1, A0, D0, S0, 0, 0, 1)); // 4
        vecs.push_back(mk(0, 1, 0, 1, DA,   1, A0, D0, S0, 1, 0, 1)); // 5 done
        vecs.push_back(mk(0, 0, 0, 0, DA,   0, A0, D0, S0, 0, 0, 1)); // 6 RELEASE
        vecs.push_back(mk(0, 0, 0, 1, DA,   0, A0, D0, S0, 0, 0, 0)); // 7 spurious in IDLE
        vecs.push_back(mk(0, 0, 0, 0, DA,   0, A0, D0, S0, 0, 0, 0)); // 8 still IDLE
        vecs.push_back(mk(1, 0, 0, 0, DA,   0, A0, D0, S0, 0, 0, 0)); // 9 reset, rr was 1
        vecs.push_back(mk(0, 1, 1, 0, DA,   0, 0,  0,  0,  0, 0, 0)); // 10 both, rr=0
        vecs.push_back(mk(0, 1, 1, 1, DA,   1, A0, D0, S0, 1, 0, 1)); // 11 GRANT0 done
        vecs.push_back(mk(0, 1, 1, 1, DA,   0, A0, D0, S0, 0, 0, 1)); // 12 RELEASE, mwd ignored
        vecs.push_back(mk(0, 1, 1, 0, DA,   0, A0, D0, S0, 0, 0, 0)); // 13 IDLE
        vecs.push_back(mk(0, 1, 1, 0, DB,   1, A1, DA, S1, 0, 0, 1)); // 14 GRANT1, data changes
        vecs.push_back(mk(0, 1, 0, 0, DB,   1, A1, DA, S1, 0, 0, 1)); // 15 req1 drops
        vecs.push_back(mk(0, 1, 0, 1, DB,   1, A1, DA, S1, 0, 1, 1)); // 16 done
        vecs.push_back(mk(0, 1, 1, 0, DB,   0, A1, DA, S1, 0, 0, 1)); // 17 RELEASE
        vecs.push_back(mk(0, 1, 1, 0, DB,   0, A1, DA, S1, 0, 0, 0)); // 18 IDLE
        vecs.push_back(mk(0, 1, 1, 1, DB,   1, A0, D0, S0, 1, 0, 1)); // 19 GRANT0 again
        vecs.push_back(mk(0, 1, 1, 0, DB,   0, A0, D0, S0, 0, 0, 1)); // 20 RELEASE
        vecs.push_back(mk(0, 1, 1, 0, DB,   0, A0, D0, S0, 0, 0, 0)); // 21 IDLE
        vecs.push_back(mk(0, 1, 1, 1, DB,   1, A1, DB, S1, 0, 1, 1)); // 22 GRANT1 again
        vecs.push_back(mk(0, 1, 0, 0, DB,   0, A1, DB, S1, 0, 0, 1)); // 23 RELEASE
        vecs.push_back(mk(0, 1, 0, 0, DB,   0, A1, DB, S1, 0, 0, 0)); // 24 IDLE
        vecs.push_back(mk(1, 1, 0, 1, DA,   1, A0, D0, S0, 0, 0, 0)); // 25 reset in GRANT0
        vecs.push_back(mk(0, 0, 1, 0, DA,   0, 0,  0,  0,  0, 0, 0)); // 26 req1 after reset
        vecs.push_back(mk(0, 0, 1, 0, DA,   1, A1, DA, S1, 0, 0, 1)); // 27 GRANT1
        vecs.push_back(mk(0, 0, 1, 1, DA,   1, A1, DA, S1, 0, 1, 1)); // 28 done
        vecs.push_back(mk(0, 0, 0, 0, DA,   0, A1, DA, S1, 0, 0, 1)); // 29 RELEASE
        vecs.push_back(mk(0, 0, 0, 0, DA,   0, A1, DA, S1, 0, 0, 0)); // 30 IDLE

        reset = 1'b1; req0_we = 1'b0; req1_we = 1'b0; mem_write_done = 1'b0;
        req0_address = A0; req0_data = D0; req0_select = S0;
        req1_address = A1; req1_data = DA; req1_select = S1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; req0_we = vecs[i].w0; req1_we = vecs[i].w1;
            mem_write_done = vecs[i].mwd; req1_data = vecs[i].r1d;
            #1;
            chk($sformatf("v%0d we_o", i),      {31'd0, we_o},      {31'd0, vecs[i].we});
            chk($sformatf("v%0d address_o", i), address_o,          vecs[i].addr);
            chk($sformatf("v%0d data_o", i),    data_o,             vecs[i].data);
            chk($sformatf("v%0d select_o", i),  {28'd0, select_o},  {28'd0, vecs[i].sel});
            chk($sformatf("v%0d req0_done", i), {31'd0, req0_done}, {31'd0, vecs[i].dn0});
            chk($sformatf("v%0d req1_done", i), {31'd0, req1_done}, {31'd0, vecs[i].dn1});
            chk($sformatf("v%0d busy", i),      {31'd0, busy},      {31'd0, vecs[i].bsy});
        end

        // Hand sequence: single req0, measure grant latency, drop request mid-grant, check release.
        begin
            int lat;
            @(negedge clk);
            req0_we = 1'b1; req1_we = 1'b0; mem_write_done = 1'b0;
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!we_o && lat < 6);
            chk("seq grant latency", lat, 1);
            @(negedge clk);
            req0_we = 1'b0;
            repeat (2) @(negedge clk);
            #1;
            chk("seq hold we_o", {31'd0, we_o}, 32'd1);
            chk("seq hold address_o", address_o, A0);
            mem_write_done = 1'b1;
            #1;
            chk("seq req0_done", {31'd0, req0_done}, 32'd1);
            chk("seq req1_done", {31'd0, req1_done}, 32'd0);
            @(posedge clk); #1;
            mem_write_done = 1'b0;
            chk("seq release we_o", {31'd0, we_o}, 32'd0);
            chk("seq release busy", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
            chk("seq back to idle", {31'd0, busy}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
